pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC redirect select. It resolves three hazard classes under a fixed priority:
- data-memory wait
- taken branch/jump resolved in EX
- load-use in ID

A small FSM tracks outstanding memory waits and latches a sticky timeout error.

Parameters:
MEM_TIMEOUT, 255, consecutive memory-wait cycles tolerated before the FSM enters ERROR (must be >= 2)
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  rd index of the instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch or jump
mem_req  input  1  MEM stage has an active data-memory access
mem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
fd_stall  output  1  hold IF/ID register
fd_flush  output  1  zero IF/ID instruction (bubble)
de_stall  output  1  hold ID/EX register
de_flush  output  1  insert bubble into ID/EX
em_stall  output  1  hold EX/MEM register
mw_flush  output  1  insert bubble into MEM/WB
pc_redirect  output  1  select branch target as next PC
stall_count  output  CNT_W  saturating count of cycles with pc_stall=1
mem_timeout  output  1  sticky error: memory wait exceeded MEM_TIMEOUT

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - While rst_n=0: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0, and all control outputs are forced to 0.
- Control outputs are combinational from the registered state and the current inputs, so they take effect in the same cycle. State and counters update on the rising edge of clk.
- Condition definitions:
  - mem_stall = mem_req & ~mem_ready.
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Priority, in state RUN or MEM_WAIT:
  1. mem_stall: pc_stall = fd_stall = de_stall = em_stall = 1 and mw_flush = 1. All other outputs are 0, and any branch or load-use is suppressed.
  2. else ex_branch_taken: pc_redirect = fd_flush = de_flush = 1. All stalls are 0. A load_use present in the same cycle is ignored because the ID instruction is on the wrong path.
  3. else load_use: pc_stall = fd_stall = 1 and de_flush = 1. This lasts exactly one cycle, because the load advances to MEM.
  4. else all outputs are 0.
- Deferred branch: a branch that occurs during mem_stall is held in EX by em_stall/de_stall, so ex_branch_taken stays asserted. The redirect is applied in the first cycle with mem_ready=1. The block needs no extra latch for this.
- mem_req=1 and mem_ready=1 in the same cycle: no stall (single-cycle access).
- FSM states:
  - RUN: on mem_stall, go to MEM_WAIT.
  - MEM_WAIT: on ~mem_stall, go to RUN.
  - ERROR: entered from RUN or MEM_WAIT when wait_cnt == MEM_TIMEOUT-1 and mem_stall=1 at the clock edge.
    - In ERROR, pc_stall, fd_stall, de_stall and em_stall are held at 1 and mw_flush=1. All other outputs are 0, and mem_timeout=1.
    - ERROR exits only on reset.
- wait_cnt: increments on each edge where mem_stall=1 and clears on each edge where mem_stall=0. ERROR is therefore entered after exactly MEM_TIMEOUT consecutive stalled cycles.
- stall_count: increments on each edge where pc_stall=1, including in ERROR, and saturates at all ones.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=fd_stall=de_flush=1 for that cycle only, and stall_count goes 0->1. Repeat with ex_rd=0 -> no stall.
2. Branch with simultaneous load-use: ex_branch_taken=1 plus the load-use inputs of test 1 -> pc_redirect=fd_flush=de_flush=1 and pc_stall=0, with stall_count unchanged.
3. Memory wait with pending branch: mem_req=1, mem_ready=0 for 3 cycles, ex_branch_taken=1 throughout.
   - During the wait: 4 stalls=1, mw_flush=1, pc_redirect=0, and state=MEM_WAIT from the second cycle.
   - Cycle with mem_ready=1: pc_redirect=fd_flush=1 and all stalls=0.
   - stall_count=3 afterwards.
4. Zero-wait access: mem_req=1, mem_ready=1 -> no outputs asserted and state remains RUN.
5. Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held.
   - mem_timeout=1 after the 4th edge.
   - Stalls remain asserted after mem_ready returns to 1.
   - Only rst_n=0 clears the error.
6. Async reset mid-wait: rst_n dropped between clock edges during MEM_WAIT -> all outputs go to 0 immediately, and state=RUN and stall_count=0 after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Hazard-control bundle between the 5-stage pipeline datapath and the
// stall/flush sequencer.
//   Hazard inputs  : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
//                    ex_mem_read, ex_branch_taken, mem_req, mem_ready
//   Control outputs: pc_stall, fd_stall, fd_flush, de_stall, de_flush,
//                    em_stall, mw_flush, pc_redirect
//   Status outputs : stall_count[CNT_W-1:0], mem_timeout
// master = datapath side (drives hazard inputs), slave = sequencer.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_stall;
    logic             fd_stall;
    logic             fd_flush;
    logic             de_stall;
    logic             de_flush;
    logic             em_stall;
    logic             mw_flush;
    logic             pc_redirect;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        input  pc_stall, fd_stall, fd_flush, de_stall, de_flush,
               em_stall, mw_flush, pc_redirect, stall_count, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        output pc_stall, fd_stall, fd_flush, de_stall, de_flush,
               em_stall, mw_flush, pc_redirect, stall_count, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Resolves, in
// priority order: data-memory wait, taken branch/jump in EX, load-use in ID.
// A small FSM tracks consecutive memory-wait cycles and latches a sticky
// timeout error that only reset clears.
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs,
//           saturating stall counter, sticky mem_timeout)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    // Counter only needs to reach MEM_TIMEOUT-1; it holds there while stalled.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_count;

    logic w_mem_stall;
    logic w_load_use;
    logic w_pc_stall;
    logic w_fd_stall;
    logic w_fd_flush;
    logic w_de_stall;
    logic w_de_flush;
    logic w_em_stall;
    logic w_mw_flush;
    logic w_pc_redirect;

    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;
    assign w_load_use  = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                         ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                          (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt == WAIT_LAST) w_state_nxt = ST_ERROR;
                    else                         w_state_nxt = ST_MEM_WAIT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Control outputs. Gated by rst_n so they drop to 0 the moment reset is
    // asserted, not at the next edge. A branch seen during a memory wait stays
    // in EX (held by em_stall/de_stall) and is redirected once the wait ends.
    always_comb begin
        w_pc_stall    = 1'b0;
        w_fd_stall    = 1'b0;
        w_fd_flush    = 1'b0;
        w_de_stall    = 1'b0;
        w_de_flush    = 1'b0;
        w_em_stall    = 1'b0;
        w_mw_flush    = 1'b0;
        w_pc_redirect = 1'b0;
        if (rst_n) begin
            if (r_state == ST_ERROR || w_mem_stall) begin
                w_pc_stall = 1'b1;
                w_fd_stall = 1'b1;
                w_de_stall = 1'b1;
                w_em_stall = 1'b1;
                w_mw_flush = 1'b1;
            end else if (bus.ex_branch_taken) begin
                w_pc_redirect = 1'b1;
                w_fd_flush    = 1'b1;
                w_de_flush    = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall = 1'b1;
                w_fd_stall = 1'b1;
                w_de_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (!w_mem_stall)              r_wait_cnt <= '0;
            else if (r_wait_cnt != WAIT_LAST) r_wait_cnt <= r_wait_cnt + 1'b1;

            if (w_pc_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.pc_stall    = w_pc_stall;
    assign bus.fd_stall    = w_fd_stall;
    assign bus.fd_flush    = w_fd_flush;
    assign bus.de_stall    = w_de_stall;
    assign bus.de_flush    = w_de_flush;
    assign bus.em_stall    = w_em_stall;
    assign bus.mw_flush    = w_mw_flush;
    assign bus.pc_redirect = w_pc_redirect;
    assign bus.stall_count = r_stall_count;
    assign bus.mem_timeout = (r_state == ST_ERROR);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed vectors with hand-computed expectations pushed into a queue by the
// driver; a separate monitor pops and compares each cycle on the falling edge.
// DUT built with MEM_TIMEOUT=4 and CNT_W=4 so timeout and counter saturation
// are reachable in a short run.
// Output vector bit order:
//   {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush,
//    pc_redirect}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0010_1001;
    localparam logic [7:0] O_MS   = 8'b1101_0110;

    typedef struct {
        int         idx;
        logic [7:0] o;
        logic [3:0] sc;
        logic       to;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   vidx;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector shortly after the rising edge and queue its expectation.
    task automatic v(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic mrd, input logic br, input logic req, input logic rdy,
                     input logic [7:0] eo, input logic [3:0] esc, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n               = rst;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_use_rs1      = u1;
        bus.id_use_rs2      = u2;
        bus.ex_rd           = rd;
        bus.ex_mem_read     = mrd;
        bus.ex_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
        e.idx = vidx;
        e.o   = eo;
        e.sc  = esc;
        e.to  = eto;
        exp_q.push_back(e);
        vidx++;
    endtask

    // Monitor: outputs are valid every cycle once a vector is in flight.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = {bus.pc_stall, bus.fd_stall, bus.fd_flush, bus.de_stall,
                   bus.de_flush, bus.em_stall, bus.mw_flush, bus.pc_redirect};
            n_vec++;
            if (act !== e.o || bus.stall_count !== e.sc || bus.mem_timeout !== e.to) begin
                n_err++;
                $display("FAIL vec%0d: ctrl=%b sc=%0d to=%b, expected ctrl=%b sc=%0d to=%b",
                         e.idx, act, bus.stall_count, bus.mem_timeout, e.o, e.sc, e.to);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        vidx  = 0;
        rst_n = 1'b0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rd = '0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

        //  rst rs1 rs2 u1 u2 rd mrd br req rdy  exp      sc  to
        // Reset holds outputs at 0 even with hazards present
        v(0,  0,  0,  0, 0, 0, 0,  1, 1,  0,  O_NONE,  0, 0);   // 0
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  0, 0);   // 1
        // Load-use on rs1, then rd=0 no hazard, rs2 hazard, use-flag gating
        v(1,  5,  0,  1, 0, 5, 1,  0, 0,  0,  O_LU,    0, 0);   // 2
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  1, 0);   // 3
        v(1,  0,  0,  1, 0, 0, 1,  0, 0,  0,  O_NONE,  1, 0);   // 4
        v(1,  3,  7,  1, 1, 7, 1,  0, 0,  0,  O_LU,    1, 0);   // 5
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  2, 0);   // 6
        v(1,  0,  7,  0, 0, 7, 1,  0, 0,  0,  O_NONE,  2, 0);   // 7
        // Branch beats load-use
        v(1,  5,  0,  1, 0, 5, 1,  1, 0,  0,  O_BR,    2, 0);   // 8
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  2, 0);   // 9
        // Three-cycle memory wait with pending branch, then deferred redirect
        v(1,  0,  0,  0, 0, 0, 0,  1, 1,  0,  O_MS,    2, 0);   // 10
        v(1,  0,  0,  0, 0, 0, 0,  1, 1,  0,  O_MS,    3, 0);   // 11
        v(1,  0,  0,  0, 0, 0, 0,  1, 1,  0,  O_MS,    4, 0);   // 12
        v(1,  0,  0,  0, 0, 0, 0,  1, 1,  1,  O_BR,    5, 0);   // 13
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  5, 0);   // 14
        // Memory wait suppresses load-use, which then applies once ready
        v(1,  5,  0,  1, 0, 5, 1,  0, 1,  0,  O_MS,    5, 0);   // 15
        v(1,  5,  0,  1, 0, 5, 1,  0, 1,  1,  O_LU,    6, 0);   // 16
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  7, 0);   // 17
        // Zero-wait access
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  1,  O_NONE,  7, 0);   // 18
        // Timeout: ERROR after the 4th stalled edge, sticky afterwards
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    7, 0);   // 19
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    8, 0);   // 20
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    9, 0);   // 21
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,   10, 0);   // 22
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  1,  O_MS,   11, 1);   // 23
        v(1,  5,  0,  1, 0, 5, 1,  1, 0,  0,  O_MS,   12, 1);   // 24
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_MS,   13, 1);   // 25
        // Reset clears the error
        v(0,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  0, 0);   // 26
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  0, 0);   // 27
        // Asynchronous reset mid-wait: outputs drop immediately
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    0, 0);   // 28
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    1, 0);   // 29
        v(0,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_NONE,  0, 0);   // 30
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_NONE,  0, 0);   // 31
        // wait counter restarted from 0: full 4 stalled edges needed again
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    0, 0);   // 32
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    1, 0);   // 33
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    2, 0);   // 34
        v(1,  0,  0,  0, 0, 0, 0,  0, 1,  0,  O_MS,    3, 0);   // 35
        v(1,  0,  0,  0, 0, 0, 0,  0, 0,  0,  O_MS,    4, 1);   // 36
        // Stall counter counts on in ERROR and saturates at 15
        for (int k = 0; k < 12; k++) begin
            v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MS, ((5 + k) > 15) ? 4'd15 : 4'(5 + k), 1);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
